// File: rtl/npu_queue_bridge.sv
// CPU<->NPU queue responder: config and input queues toward the NPU,
// output queue back to the CPU, with registered status flags.
module npu_queue_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iFlush,
    input  logic         iPush,
    input  logic [W-1:0] iPushData,
    input  logic         iPop,
    output logic [W-1:0] oHeadData,
    output logic         oFull,
    output logic         oEmpty,
    output logic         oErr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push_ok, pop_ok;

    // Flags come only from the registered count.
    assign oFull     = (count_q == CW'(DEPTH));
    assign oEmpty    = (count_q == '0);
    assign oHeadData = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = iPush && !oFull && !iFlush;
        pop_ok   = iPop && !oEmpty && !iFlush;
        oErr     = !iFlush && ((iPush && oFull) || (iPop && oEmpty));
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (iFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push_ok) mem_q[wr_ptr_q] <= iPushData;
    end
endmodule

module npu_queue_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int CFG_DEPTH  = 8,
    parameter int IN_DEPTH   = 16,
    parameter int OUT_DEPTH  = 16
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iFlush,
    input  logic                  iCpuCfgWr,
    input  logic [DATA_WIDTH-1:0] iCpuCfgData,
    input  logic                  iCpuEnq,
    input  logic [DATA_WIDTH-1:0] iCpuEnqData,
    input  logic                  iCpuDeq,
    output logic [DATA_WIDTH-1:0] oCpuDeqData,
    output logic                  oNpuConfigFull,
    output logic                  oNpuInputFull,
    output logic                  oNpuOutputEmpty,
    input  logic                  iNpuCfgRd,
    output logic [DATA_WIDTH-1:0] oNpuCfgData,
    output logic                  oNpuCfgValid,
    input  logic                  iNpuInRd,
    output logic [DATA_WIDTH-1:0] oNpuInData,
    output logic                  oNpuInValid,
    input  logic                  iNpuOutWr,
    input  logic [DATA_WIDTH-1:0] iNpuOutData,
    output logic                  oNpuOutReady,
    output logic                  oProtocolErr
);
    logic cfg_empty, in_empty, out_full;
    logic cfg_err, in_err, out_err;
    logic err_q, err_d;

    npu_queue_fifo #(.W(DATA_WIDTH), .DEPTH(CFG_DEPTH)) u_cfg (
        .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush),
        .iPush(iCpuCfgWr), .iPushData(iCpuCfgData),
        .iPop(iNpuCfgRd), .oHeadData(oNpuCfgData),
        .oFull(oNpuConfigFull), .oEmpty(cfg_empty),
        .oErr(cfg_err)
    );

    npu_queue_fifo #(.W(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in (
        .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush),
        .iPush(iCpuEnq), .iPushData(iCpuEnqData),
        .iPop(iNpuInRd), .oHeadData(oNpuInData),
        .oFull(oNpuInputFull), .oEmpty(in_empty),
        .oErr(in_err)
    );

    npu_queue_fifo #(.W(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out (
        .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush),
        .iPush(iNpuOutWr), .iPushData(iNpuOutData),
        .iPop(iCpuDeq), .oHeadData(oCpuDeqData),
        .oFull(out_full), .oEmpty(oNpuOutputEmpty),
        .oErr(out_err)
    );

    assign oNpuCfgValid = !cfg_empty;
    assign oNpuInValid  = !in_empty;
    assign oNpuOutReady = !out_full;
    assign oProtocolErr = err_q;

    // Sticky until reset; flush does not clear it.
    always_comb begin
        err_d = err_q | cfg_err | in_err | out_err;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) err_q <= 1'b0;
        else         err_q <= err_d;
    end
endmodule

// File: doc/npu_queue_bridge.md
Name: npu_queue_bridge

Overview:
- Responder side of the CPU↔NPU queue protocol. Holds three FIFOs:
  - config queue: CPU→NPU
  - input queue: CPU→NPU
  - output queue: NPU→CPU
- Generates the oNpuConfigFull, oNpuInputFull and oNpuOutputEmpty status that the CPU pipeline's hazard logic consumes to stall NPU cfg/enq/deq ops in EX.
- Sits between the EX-stage NPU op decode and the NPU core.

Parameters:
- DATA_WIDTH, 32, width of every queue entry.
- CFG_DEPTH, 8, config queue entries; power of two, ≥2.
- IN_DEPTH, 16, input queue entries; power of two, ≥2.
- OUT_DEPTH, 16, output queue entries; power of two, ≥2.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iFlush  in  1  synchronous clear of all three queues.
- iCpuCfgWr  in  1  EX-stage config op; push iCpuCfgData.
- iCpuCfgData  in  DATA_WIDTH  config word.
- iCpuEnq  in  1  EX-stage enqueue op; push iCpuEnqData.
- iCpuEnqData  in  DATA_WIDTH  input word.
- iCpuDeq  in  1  EX-stage dequeue op; pop output queue head.
- oCpuDeqData  out  DATA_WIDTH  output queue head (show-ahead).
- oNpuConfigFull  out  1  config queue count == CFG_DEPTH.
- oNpuInputFull  out  1  input queue count == IN_DEPTH.
- oNpuOutputEmpty  out  1  output queue count == 0.
- iNpuCfgRd  in  1  NPU pops config head.
- oNpuCfgData  out  DATA_WIDTH  config head (show-ahead).
- oNpuCfgValid  out  1  config queue non-empty.
- iNpuInRd  in  1  NPU pops input head.
- oNpuInData  out  DATA_WIDTH  input head (show-ahead).
- oNpuInValid  out  1  input queue non-empty.
- iNpuOutWr  in  1  NPU pushes iNpuOutData.
- iNpuOutData  in  DATA_WIDTH  result word.
- oNpuOutReady  out  1  output queue not full.
- oProtocolErr  out  1  sticky: push-on-full or pop-on-empty attempted.

Behaviour:
- Each queue is a circular buffer:
  - read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH;
  - count register of log2(DEPTH)+1 bits.
- All flags decode combinationally from registered counts only, never from same-cycle push/pop inputs. Flags therefore change the cycle after the event that caused them.
- Reset (iRst_n low, asynchronous):
  - all pointers and counts = 0, oProtocolErr = 0;
  - oNpuConfigFull = 0, oNpuInputFull = 0, oNpuOutputEmpty = 1;
  - oNpuCfgValid = 0, oNpuInValid = 0, oNpuOutReady = 1.
  - Data outputs are don't-care while the queue is empty; storage is not cleared.
  - Reset asserted mid-operation discards all queued data.
- Push acceptance: accepted only if the queue is not full at cycle start. The entry is written at the write pointer; the write pointer and count are updated at the edge.
- Pop acceptance: accepted only if the queue is non-empty at cycle start. The read pointer advances; the head data shown that cycle is the popped value.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Full queue, push and pop in the same cycle: pop accepted, push rejected. No bypass; the producer is stalled by the full flag.
- Empty queue, push and pop in the same cycle: push accepted, pop rejected. No write-through bypass; data is visible the next cycle.
- Rejected push or pop: state unchanged, oProtocolErr set to 1. It stays set until reset.
  - iCpuDeq on an empty queue is a rejected pop and sets the error.
  - Under correct stalling this never occurs.
- Write latency: 1 cycle; an entry is visible at the consumer head the cycle after its push.
- iFlush: at the next edge, all pointers and counts = 0. It overrides any same-cycle push or pop, which are ignored without setting oProtocolErr. oProtocolErr itself is not cleared.
- Queues are fully independent; operations on different queues in the same cycle never interact.

Test Plan:
- Reset with iRst_n=0 mid-stream, 5 entries in the input queue → outputs go to reset values immediately (asynchronous): oNpuOutputEmpty=1, oNpuInValid=0, oNpuInputFull=0.
- 16 iCpuEnq pushes of 0x100..0x10F with no NPU pops → oNpuInputFull=1 the cycle after the 16th push. A 17th push is dropped and oProtocolErr=1. 16 iNpuInRd pops then return 0x100..0x10F in order.
- Input queue full, iCpuEnq and iNpuInRd in the same cycle → pop returns 0x100, push dropped, count=15, oNpuInputFull=0 next cycle, oProtocolErr=1.
- Output queue empty, iNpuOutWr of 0xDEADBEEF together with iCpuDeq → deq rejected. Next cycle oNpuOutputEmpty=0 and oCpuDeqData=0xDEADBEEF.
- Steady streaming through the config queue (push and pop every cycle for 40 cycles, values 0..39, pointers wrap 5×) → data in order, count constant at 1, oNpuConfigFull never asserted.
- 3 entries in each queue, iFlush pulsed with a same-cycle push → all counts=0 next cycle, oNpuOutputEmpty=1, oNpuCfgValid=0, oNpuInValid=0, oProtocolErr unchanged.
